// File: rtl/sbf_pkg.sv
// Shared helpers for the single-bit-flip error collector: saturating increment
// and index-width derivation.
package sbf_pkg;

  // Returns {next_count, ovf}; only the low width+1 bits are meaningful.
  function automatic logic [32:0] sat_inc(input logic [31:0] count, input int width);
    logic [31:0] mask;
    mask = 32'hFFFF_FFFF >> (32 - width);
    if ((count & mask) == mask) begin
      sat_inc = {count & mask, 1'b1};
    end else begin
      sat_inc = {(count & mask) + 32'd1, 1'b0};
    end
  endfunction

  function automatic int idx_w(input int n);
    idx_w = (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/sbf_err_cnt.sv
// One source slice: edge detector, sticky status, saturating counter and
// overflow flag. Next-state values are exported for the top-level irq reduction.
module sbf_err_cnt
  import sbf_pkg::*;
#(
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk_i,
  input  logic                 rstn_i,
  input  logic                 error_i,
  input  logic                 en_i,
  input  logic                 clear_i,
  output logic                 event_o,
  output logic                 next_status_o,
  output logic [CNT_WIDTH-1:0] next_count_o,
  output logic                 status_o,
  output logic [CNT_WIDTH-1:0] count_o,
  output logic                 overflow_o
);

  logic                 err_q_r;
  logic                 status_r;
  logic [CNT_WIDTH-1:0] count_r;
  logic                 ovf_r;
  logic                 event_s;
  logic                 base_status_s;
  logic [CNT_WIDTH-1:0] base_count_s;
  logic                 base_ovf_s;
  logic [CNT_WIDTH:0]   inc_s;
  logic                 next_status_s;
  logic [CNT_WIDTH-1:0] next_count_s;
  logic                 next_ovf_s;

  // Clear is applied first, then the event acts on the cleared values.
  always_comb begin
    event_s = error_i & ~err_q_r & en_i;
    if (clear_i) begin
      base_status_s = 1'b0;
      base_count_s  = '0;
      base_ovf_s    = 1'b0;
    end else begin
      base_status_s = status_r;
      base_count_s  = count_r;
      base_ovf_s    = ovf_r;
    end
    inc_s = (CNT_WIDTH+1)'(sat_inc(32'(base_count_s), CNT_WIDTH));
    if (event_s) begin
      next_status_s = 1'b1;
      next_count_s  = inc_s[CNT_WIDTH:1];
      next_ovf_s    = base_ovf_s | inc_s[0];
    end else begin
      next_status_s = base_status_s;
      next_count_s  = base_count_s;
      next_ovf_s    = base_ovf_s;
    end
  end

  // Slice state registers; err_q samples every cycle independent of enable.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      err_q_r  <= 1'b0;
      status_r <= 1'b0;
      count_r  <= '0;
      ovf_r    <= 1'b0;
    end else begin
      err_q_r  <= error_i;
      status_r <= next_status_s;
      count_r  <= next_count_s;
      ovf_r    <= next_ovf_s;
    end
  end

  assign event_o       = event_s;
  assign next_status_o = next_status_s;
  assign next_count_o  = next_count_s;
  assign status_o      = status_r;
  assign count_o       = count_r;
  assign overflow_o    = ovf_r;

endmodule

// File: rtl/sbf_err_collector.sv
// Collects N_SRC detector error lines into per-source sticky status/counters,
// captures the first faulting source and raises a threshold interrupt.
module sbf_err_collector
  import sbf_pkg::*;
#(
  parameter int N_SRC     = 8,
  parameter int CNT_WIDTH = 16,
  localparam int IDX_WIDTH = idx_w(N_SRC)
) (
  input  logic                       clk_i,
  input  logic                       rstn_i,
  input  logic [N_SRC-1:0]           error_i,
  input  logic                       en_i,
  input  logic [N_SRC-1:0]           clear_i,
  input  logic [CNT_WIDTH-1:0]       thr_i,
  output logic [N_SRC-1:0]           status_o,
  output logic [N_SRC*CNT_WIDTH-1:0] count_o,
  output logic [N_SRC-1:0]           overflow_o,
  output logic                       first_valid_o,
  output logic [IDX_WIDTH-1:0]       first_idx_o,
  output logic                       irq_o
);

  logic [N_SRC-1:0]     event_s;
  logic [N_SRC-1:0]     next_status_s;
  logic [CNT_WIDTH-1:0] next_count_s [N_SRC];
  logic                 first_valid_r;
  logic [IDX_WIDTH-1:0] first_idx_r;
  logic                 irq_r;
  logic                 next_fv_s;
  logic [IDX_WIDTH-1:0] next_fi_s;
  logic                 next_irq_s;
  logic [CNT_WIDTH-1:0] thr_eff_s;

  for (genvar k = 0; k < N_SRC; k++) begin : g_src
    sbf_err_cnt #(.CNT_WIDTH(CNT_WIDTH)) u_cnt (
      .clk_i         (clk_i),
      .rstn_i        (rstn_i),
      .error_i       (error_i[k]),
      .en_i          (en_i),
      .clear_i       (clear_i[k]),
      .event_o       (event_s[k]),
      .next_status_o (next_status_s[k]),
      .next_count_o  (next_count_s[k]),
      .status_o      (status_o[k]),
      .count_o       (count_o[k*CNT_WIDTH +: CNT_WIDTH]),
      .overflow_o    (overflow_o[k])
    );
  end

  // First-error capture: drop on clear of the held source, then lowest-index capture.
  always_comb begin
    next_fi_s = first_idx_r;
    if (first_valid_r && clear_i[first_idx_r]) begin
      next_fv_s = 1'b0;
    end else begin
      next_fv_s = first_valid_r;
    end
    if (!next_fv_s && (|event_s)) begin
      next_fv_s = 1'b1;
      for (int k = N_SRC - 1; k >= 0; k--) begin
        if (event_s[k]) begin
          next_fi_s = IDX_WIDTH'(k);
        end else begin
          next_fi_s = next_fi_s;
        end
      end
    end else begin
      next_fv_s = next_fv_s;
    end
  end

  // Interrupt reduction on next-state values; a zero threshold behaves as one.
  always_comb begin
    thr_eff_s  = (thr_i == '0) ? CNT_WIDTH'(1) : thr_i;
    next_irq_s = 1'b0;
    for (int k = 0; k < N_SRC; k++) begin
      if (next_status_s[k] && (next_count_s[k] >= thr_eff_s)) begin
        next_irq_s = 1'b1;
      end else begin
        next_irq_s = next_irq_s;
      end
    end
  end

  // Capture and interrupt registers.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      first_valid_r <= 1'b0;
      first_idx_r   <= '0;
      irq_r         <= 1'b0;
    end else begin
      first_valid_r <= next_fv_s;
      first_idx_r   <= next_fi_s;
      irq_r         <= next_irq_s;
    end
  end

  assign first_valid_o = first_valid_r;
  assign first_idx_o   = first_idx_r;
  assign irq_o         = irq_r;

endmodule

// File: tb/tb_sbf_err_collector.sv
// Directed plus randomized bench for sbf_err_collector against a per-source
// behavioural model (N_SRC=8, CNT_WIDTH=4 so saturation is reachable quickly).
module tb_sbf_err_collector;

  localparam int N   = 8;
  localparam int CW  = 4;
  localparam int MAXC = 15;

  logic          tb_clk_i = 1'b0;
  logic          rstn_i;
  logic [N-1:0]  error_i;
  logic          en_i;
  logic [N-1:0]  clear_i;
  logic [CW-1:0] thr_i;
  logic [N-1:0]  status_o;
  logic [N*CW-1:0] count_o;
  logic [N-1:0]  overflow_o;
  logic          first_valid_o;
  logic [2:0]    first_idx_o;
  logic          irq_o;

  int checks = 0;
  int errors = 0;

  int m_cnt [N];
  bit m_st  [N];
  bit m_ov  [N];
  bit m_prev[N];
  bit m_fv;
  int m_fi;
  bit m_irq;

  sbf_err_collector #(.N_SRC(N), .CNT_WIDTH(CW)) dut (
    .clk_i         (tb_clk_i),
    .rstn_i        (rstn_i),
    .error_i       (error_i),
    .en_i          (en_i),
    .clear_i       (clear_i),
    .thr_i         (thr_i),
    .status_o      (status_o),
    .count_o       (count_o),
    .overflow_o    (overflow_o),
    .first_valid_o (first_valid_o),
    .first_idx_o   (first_idx_o),
    .irq_o         (irq_o)
  );

  always #5 tb_clk_i = ~tb_clk_i;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < N; k++) begin
      m_cnt[k] = 0; m_st[k] = 0; m_ov[k] = 0; m_prev[k] = 0;
    end
    m_fv = 0; m_fi = 0; m_irq = 0;
  endtask

  task automatic model_edge(input logic [N-1:0] err, input bit en,
                            input logic [N-1:0] clr, input int thr);
    bit ev [N];
    bit any;
    int t;
    any = 0;
    for (int k = 0; k < N; k++) begin
      ev[k] = err[k] && !m_prev[k] && en;
      any |= ev[k];
      if (clr[k]) begin m_cnt[k] = 0; m_st[k] = 0; m_ov[k] = 0; end
      if (ev[k]) begin
        m_st[k] = 1;
        if (m_cnt[k] == MAXC) m_ov[k] = 1; else m_cnt[k] = m_cnt[k] + 1;
      end
      m_prev[k] = err[k];
    end
    if (m_fv && clr[m_fi]) m_fv = 0;
    if (!m_fv && any) begin
      m_fv = 1;
      for (int k = N - 1; k >= 0; k--) if (ev[k]) m_fi = k;
    end
    t = (thr == 0) ? 1 : thr;
    m_irq = 0;
    for (int k = 0; k < N; k++) if (m_st[k] && m_cnt[k] >= t) m_irq = 1;
  endtask

  task automatic check_all(input string tag);
    logic [31:0] e_st, e_cnt, e_ov;
    e_st = 0; e_cnt = 0; e_ov = 0;
    for (int k = 0; k < N; k++) begin
      e_st[k] = m_st[k];
      e_ov[k] = m_ov[k];
      e_cnt   = e_cnt | (32'(m_cnt[k]) << (CW * k));
    end
    chk({tag, ".status"},   32'(status_o),      e_st);
    chk({tag, ".count"},    32'(count_o),       e_cnt);
    chk({tag, ".overflow"}, 32'(overflow_o),    e_ov);
    chk({tag, ".fvalid"},   32'(first_valid_o), 32'(m_fv));
    chk({tag, ".fidx"},     32'(first_idx_o),   32'(m_fi));
    chk({tag, ".irq"},      32'(irq_o),         32'(m_irq));
  endtask

  // Drive at negedge, model the posedge, compare 1 time unit later.
  task automatic step(input string tag, input logic [N-1:0] err, input bit en,
                      input logic [N-1:0] clr, input int thr);
    error_i = err; en_i = en; clear_i = clr; thr_i = CW'(thr);
    @(posedge tb_clk_i);
    model_edge(err, en, clr, thr);
    #1;
    check_all(tag);
    @(negedge tb_clk_i);
  endtask

  function automatic logic [31:0] cnt_of(input int k);
    logic [N*CW-1:0] v;
    v = count_o;
    return 32'(v[k*CW +: CW]);
  endfunction

  initial begin
    logic [N-1:0] r_err;
    rstn_i = 1'b0; error_i = '0; en_i = 1'b1; clear_i = '0; thr_i = '0;
    model_reset();
    #12;
    check_all("reset");
    @(negedge tb_clk_i);
    rstn_i = 1'b1;

    // Single episode on source 3.
    for (int i = 0; i < 5; i++) step("single", 8'h08, 1'b1, 8'h00, 1);
    step("single_low", 8'h00, 1'b1, 8'h00, 1);
    chk("single_status", 32'(status_o), 32'h08);
    chk("single_cnt3", cnt_of(3), 32'd1);
    chk("single_fidx", 32'(first_idx_o), 32'd3);
    step("clr", 8'h00, 1'b1, 8'hFF, 3);

    // Threshold of three pulses on source 0.
    for (int p = 1; p <= 3; p++) begin
      step("thr_hi", 8'h01, 1'b1, 8'h00, 3);
      step("thr_hi", 8'h01, 1'b1, 8'h00, 3);
      step("thr_lo", 8'h00, 1'b1, 8'h00, 3);
      chk("thr_irq", 32'(irq_o), (p == 3) ? 32'd1 : 32'd0);
    end
    chk("thr_cnt0", cnt_of(0), 32'd3);
    step("clr", 8'h00, 1'b1, 8'hFF, 1);

    // Simultaneous sources then later rise on bit 0.
    step("simul", 8'h24, 1'b1, 8'h00, 1);
    chk("simul_fidx", 32'(first_idx_o), 32'd2);
    step("later", 8'h25, 1'b1, 8'h00, 1);
    chk("later_fidx", 32'(first_idx_o), 32'd2);
    step("clr2", 8'h00, 1'b1, 8'h04, 1);
    chk("clr2_fvalid", 32'(first_valid_o), 32'd0);
    chk("clr2_status", 32'(status_o & 8'h24), 32'h20);
    step("clr", 8'h00, 1'b1, 8'hFF, 1);

    // Clear and event collide on source 1.
    for (int p = 0; p < 5; p++) begin
      step("coll_hi", 8'h02, 1'b1, 8'h00, 1);
      step("coll_lo", 8'h00, 1'b1, 8'h00, 1);
    end
    chk("coll_pre", cnt_of(1), 32'd5);
    step("coll", 8'h02, 1'b1, 8'h02, 1);
    chk("coll_cnt1", cnt_of(1), 32'd1);
    chk("coll_ovf", 32'(overflow_o[1]), 32'd0);
    step("clr", 8'h00, 1'b1, 8'hFF, 1);

    // Saturation on source 7.
    for (int p = 1; p <= 17; p++) begin
      step("sat_hi", 8'h80, 1'b1, 8'h00, 15);
      step("sat_lo", 8'h00, 1'b1, 8'h00, 15);
      chk("sat_ovf", 32'(overflow_o[7]), (p >= 16) ? 32'd1 : 32'd0);
    end
    chk("sat_cnt7", cnt_of(7), 32'd15);
    step("clr", 8'h00, 1'b1, 8'hFF, 1);

    // Enable while held high, then reset mid-episode.
    step("en_off", 8'h10, 1'b0, 8'h00, 1);
    step("en_on", 8'h10, 1'b1, 8'h00, 1);
    chk("en_no_evt", cnt_of(4), 32'd0);
    #2;
    rstn_i = 1'b0;
    model_reset();
    #1;
    check_all("midrst");
    @(negedge tb_clk_i);
    rstn_i = 1'b1;
    step("post_rst", 8'h10, 1'b1, 8'h00, 1);
    chk("post_rst_cnt4", cnt_of(4), 32'd1);

    // Randomized traffic with sparse clears and varying thresholds.
    r_err = '0;
    for (int i = 0; i < 400; i++) begin
      r_err = r_err ^ (N'($urandom) & N'($urandom));
      step("rand", r_err, ($urandom_range(0, 7) != 0),
           N'($urandom) & N'($urandom) & N'($urandom) & N'($urandom),
           int'($urandom_range(0, 6)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
